// File: rtl/router_inject_port_if.sv
// Terminal handshake, router channel and credit return of router_inject_port.
// ROUTER_INJECT_STATS_EN adds the stat_flits / stat_stalls counters.
interface router_inject_port_if #(
   parameter int FLIT_DATA_WIDTH = 64
);
   logic                       in_valid;
   logic                       in_ready;
   logic [FLIT_DATA_WIDTH-1:0] in_data;
   logic                       in_vc;
   logic                       in_last;
   logic [0:FLIT_DATA_WIDTH+3] channel_out;
   logic [0:1]                 flow_ctrl_in;
   logic                       error;
`ifdef ROUTER_INJECT_STATS_EN
   logic [15:0]                stat_flits;
   logic [15:0]                stat_stalls;
`endif

   modport slave (
      input  in_valid, in_data, in_vc, in_last, flow_ctrl_in,
      output in_ready, channel_out, error
`ifdef ROUTER_INJECT_STATS_EN
      , output stat_flits, stat_stalls
`endif
   );

   modport master (
      output in_valid, in_data, in_vc, in_last, flow_ctrl_in,
      input  in_ready, channel_out, error
`ifdef ROUTER_INJECT_STATS_EN
      , input stat_flits, stat_stalls
`endif
   );
endinterface

// File: rtl/router_inject_port.sv
// Credit-based flit injector for one router input port: frames a terminal stream
// into head/body/tail flits on a locked VC. Optional counters: ROUTER_INJECT_STATS_EN.
module router_inject_port #(
   parameter int FLIT_DATA_WIDTH = 64,
   parameter int CREDITS_PER_VC  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   router_inject_port_if.slave   port_if
);
   localparam int         CH_W     = FLIT_DATA_WIDTH + 4;
   localparam logic [3:0] CRED_MAX = 4'(CREDITS_PER_VC);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BODY = 1'b1
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic             cur_vc_r;
   logic             cur_vc_nxt_s;
   logic [3:0]       credit_r      [2];
   logic [3:0]       credit_nxt_s  [2];
   logic [1:0]       ovf_s;
   logic             error_r;
   logic [0:CH_W-1]  channel_r;
   logic [0:CH_W-1]  channel_nxt_s;
   logic             eff_vc_s;
   logic             ready_s;
   logic             accept_s;
   logic             head_s;
   logic             tail_s;
   logic             ret_valid_s;
   logic             ret_vc_s;

   // Returns {overflow, next_count}; a return on a full counter is refused.
   function automatic logic [4:0] credit_step(input logic [3:0] cur,
                                              input logic       send,
                                              input logic       ret,
                                              input logic [3:0] max);
      logic [4:0] res;
      res = {1'b0, cur};
      case ({send, ret})
         2'b10: res = {1'b0, cur - 4'd1};
         2'b01: begin
            if (cur == max) begin
               res = {1'b1, cur};
            end else begin
               res = {1'b0, cur + 4'd1};
            end
         end
         default: res = {1'b0, cur};
      endcase
      return res;
   endfunction

   assign ret_valid_s = port_if.flow_ctrl_in[0];
   assign ret_vc_s    = port_if.flow_ctrl_in[1];
   assign eff_vc_s    = (state_r == ST_BODY) ? cur_vc_r : port_if.in_vc;
   assign ready_s     = !reset && (credit_r[eff_vc_s] != 4'd0);
   assign accept_s    = port_if.in_valid && ready_s;

   // Packet framing FSM: head marks the first flit, VC locks until the tail.
   always_comb begin
      state_nxt_s  = state_r;
      cur_vc_nxt_s = cur_vc_r;
      head_s       = 1'b0;
      tail_s       = port_if.in_last;
      case (state_r)
         ST_IDLE: begin
            head_s = 1'b1;
            if (accept_s) begin
               cur_vc_nxt_s = port_if.in_vc;
               if (port_if.in_last) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_BODY;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BODY: begin
            if (accept_s && port_if.in_last) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_BODY;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Per-VC credit accounting; send and return in one cycle cancel out.
   always_comb begin
      for (int v = 0; v < 2; v++) begin
         {ovf_s[v], credit_nxt_s[v]} = credit_step(credit_r[v],
                                                   accept_s && (eff_vc_s == 1'(v)),
                                                   ret_valid_s && (ret_vc_s == 1'(v)),
                                                   CRED_MAX);
      end
   end

   // Next channel word; vc/data hold their last value on idle cycles.
   always_comb begin
      channel_nxt_s      = channel_r;
      channel_nxt_s[0:2] = 3'b000;
      if (accept_s) begin
         channel_nxt_s[0]        = 1'b1;
         channel_nxt_s[1]        = head_s;
         channel_nxt_s[2]        = tail_s;
         channel_nxt_s[3]        = eff_vc_s;
         channel_nxt_s[4:CH_W-1] = port_if.in_data;
      end else begin
         channel_nxt_s[3:CH_W-1] = channel_r[3:CH_W-1];
      end
   end

   // State, credit, channel and sticky error registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         cur_vc_r    <= 1'b0;
         credit_r[0] <= CRED_MAX;
         credit_r[1] <= CRED_MAX;
         error_r     <= 1'b0;
         channel_r   <= {CH_W{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         cur_vc_r    <= cur_vc_nxt_s;
         credit_r[0] <= credit_nxt_s[0];
         credit_r[1] <= credit_nxt_s[1];
         error_r     <= error_r | (|ovf_s);
         channel_r   <= channel_nxt_s;
      end
   end

   assign port_if.in_ready    = ready_s;
   assign port_if.channel_out = channel_r;
   assign port_if.error       = error_r;

`ifdef ROUTER_INJECT_STATS_EN
   logic [15:0] stat_flits_r;
   logic [15:0] stat_stalls_r;

   // Activity counters with natural 16-bit wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_flits_r  <= 16'd0;
         stat_stalls_r <= 16'd0;
      end else begin
         if (accept_s) begin
            stat_flits_r <= stat_flits_r + 16'd1;
         end
         if (port_if.in_valid && !ready_s) begin
            stat_stalls_r <= stat_stalls_r + 16'd1;
         end
      end
   end

   assign port_if.stat_flits  = stat_flits_r;
   assign port_if.stat_stalls = stat_stalls_r;
`endif
endmodule

// File: doc/router_inject_port.md
# router_inject_port

Credit-based flit injector sitting directly upstream of one router input port. Accepts a flit stream from a local terminal over a valid/ready handshake, frames it into head/body/tail flits on a locked virtual channel, and drives one 68-bit router input channel. Tracks per-VC downstream buffer credits from the router's 2-bit flow-control return and never sends a flit without a credit.

## Interface
Parameters:
- `FLIT_DATA_WIDTH`, 64, payload bits per flit; channel width is `FLIT_DATA_WIDTH+4`
- `CREDITS_PER_VC`, 8, router input buffer depth per VC; credit reset value (1..15)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  terminal flit valid
- `in_ready`  out  1  flit accepted when `in_valid && in_ready`
- `in_data`  in  FLIT_DATA_WIDTH  flit payload
- `in_vc`  in  1  VC for the packet; sampled on head flit only
- `in_last`  in  1  flit is the packet's last
- `channel_out`  out  [0:FLIT_DATA_WIDTH+3]  router input channel: [0] valid, [1] head, [2] tail, [3] vc, [4:] data (`in_data` MSB at [4])
- `flow_ctrl_in`  in  [0:1]  credit return: [0] credit valid, [1] credit VC
- `error`  out  1  sticky credit-overflow flag

## Operation
- FSM, two states. IDLE: next accepted flit is a head; `in_vc` latched as `cur_vc`. BODY: packet in flight, VC locked to `cur_vc`, `in_vc` ignored.
- IDLE accept with `in_last=0` -> BODY; accept with `in_last=1` -> single-flit packet (head=1, tail=1), stay IDLE. BODY accept with `in_last=1` -> tail=1, -> IDLE.
- Effective VC: `in_vc` in IDLE, `cur_vc` in BODY.
- `in_ready = !reset && credit[eff_vc] != 0`. Combinational from registers and `in_vc`; no dependence on `in_valid`.
- Per-VC credit counter, 4 bits, reset to `CREDITS_PER_VC`. Per cycle per VC: decrement on accepted flit for that VC, increment on `flow_ctrl_in[0]` with matching VC; both same cycle -> unchanged.
- Overflow: credit return for a VC whose counter equals `CREDITS_PER_VC` with no same-cycle send on it -> counter holds, `error` set; remains 1 until reset.
- Credits on the other VC are independent; a stalled packet on VC0 blocks the port (no interleaving of packets).

## Timing
- Reset values: `channel_out` all zero, `in_ready` 0 while reset asserted, `error` 0, state IDLE, credits = `CREDITS_PER_VC`.
- Latency: accepted flit appears on `channel_out` exactly 1 cycle later (registered); `channel_out[0]`=0 in cycles with no accept; data/vc fields hold previous value when invalid is not required—bench checks fields only when valid.
- Credit returned in cycle N makes `in_ready` visible in cycle N+1 (counter registered).
- Back-to-back: one flit per cycle sustained while credits > 0.
- Reset mid-packet: next cycle `channel_out[0]`=0, state IDLE, credits restored; partial packet abandoned (router-side cleanup is the router's concern).

## Configuration
- `ROUTER_INJECT_STATS_EN` defined: adds outputs `stat_flits` (16 bits, count of accepted flits) and `stat_stalls` (16 bits, cycles with `in_valid && !in_ready`); both wrap at 2^16, clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Single-flit packet, VC1, data 0xDEADBEEF_00000001, `in_last`=1 -> next cycle `channel_out` [0..3]=1,1,1,1, data matches; credit[1] 8->7.
- 3-flit packet VC0, `in_vc` toggled on flits 2-3 -> flits carry vc=0, head only on first, tail only on third; FSM back to IDLE.
- 9 consecutive flits VC0, no credit return -> first 8 accepted on consecutive cycles, `in_ready`=0 on 9th; one credit return VC0 -> 9th accepted the following cycle.
- Credit return VC0 in same cycle as VC0 send with credit=3 -> credit stays 3; credit return VC1 at 8 -> `error`=1, held until reset.
- Reset asserted during BODY of 4-flit packet -> next cycle `channel_out[0]`=0, credits both 8, next accepted flit has head=1.
- With `ROUTER_INJECT_STATS_EN`: 10 flits, 3 stall cycles -> `stat_flits`=10, `stat_stalls`=3.
